// File: rtl/ws2812_frame_ctrl.sv
// Frame sequencer for a WS2812 strip: reads pixels from a synchronous RAM, scales
// them by a global brightness, feeds them to the single-pixel driver, then latches.
module ws2812_frame_ctrl #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_leds,
  input  logic [7:0]        brightness,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_rd_en,
  input  logic [23:0]       pix_data,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              load,
  output logic              ws_reset,
  input  logic              ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned GW = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, CAPTURE, WAIT_RDY, LOAD, GUARD,
    LATCH_WAIT, LATCH, LATCH_GUARD, DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q, cnt_q, pix_addr_q;
  logic [7:0]        br_q, r_q, g_q, b_q;
  logic [7:0]        r_d, g_d, b_d;
  logic [GW-1:0]     guard_q;
  logic              pix_rd_en_q, load_q, ws_reset_q, busy_q, done_q;

  // (c * (br+1)) >> 8: br=255 passes c through, br=0 yields 0.
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] s);
    logic [16:0] p;
    p = {9'd0, c} * ({9'd0, s} + 17'd1);
    return p[15:8];
  endfunction

  always_comb begin
    r_d = scale(pix_data[23:16], br_q);
    g_d = scale(pix_data[15:8],  br_q);
    b_d = scale(pix_data[7:0],   br_q);
  end

  // Outputs are registered on the transition into the state that owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      br_q        <= '0;
      pix_addr_q  <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      guard_q     <= '0;
      pix_rd_en_q <= 1'b0;
      load_q      <= 1'b0;
      ws_reset_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pix_rd_en_q <= 1'b0;
      load_q      <= 1'b0;
      ws_reset_q  <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        IDLE: if (start) begin
          cnt_q  <= num_leds;
          br_q   <= brightness;
          idx_q  <= '0;
          busy_q <= 1'b1;
          if (num_leds != '0) begin
            pix_addr_q  <= '0;
            pix_rd_en_q <= 1'b1;
            state_q     <= FETCH;
          end else begin
            state_q <= LATCH_WAIT;
          end
        end
        FETCH: state_q <= CAPTURE;
        CAPTURE: begin
          r_q     <= r_d;
          g_q     <= g_d;
          b_q     <= b_d;
          state_q <= WAIT_RDY;
        end
        WAIT_RDY: if (ready) begin
          load_q  <= 1'b1;
          state_q <= LOAD;
        end
        LOAD: begin
          guard_q <= GW'(GUARD_CYCLES);
          state_q <= GUARD;
        end
        GUARD: begin
          if (guard_q != '0) begin
            guard_q <= guard_q - 1'b1;
          end else if (ready) begin
            if (idx_q == cnt_q - 1'b1) begin
              state_q <= LATCH_WAIT;
            end else begin
              idx_q       <= idx_q + 1'b1;
              pix_addr_q  <= idx_q + 1'b1;
              pix_rd_en_q <= 1'b1;
              state_q     <= FETCH;
            end
          end
        end
        LATCH_WAIT: if (ready) begin
          ws_reset_q <= 1'b1;
          state_q    <= LATCH;
        end
        LATCH: begin
          guard_q <= GW'(GUARD_CYCLES);
          state_q <= LATCH_GUARD;
        end
        LATCH_GUARD: begin
          if (guard_q != '0) begin
            guard_q <= guard_q - 1'b1;
          end else if (ready) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pix_addr  = pix_addr_q;
  assign pix_rd_en = pix_rd_en_q;
  assign r         = r_q;
  assign g         = g_q;
  assign b         = b_q;
  assign load      = load_q;
  assign ws_reset  = ws_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Bench for ws2812_frame_ctrl: pixel RAM + driver model, fixed scaling vectors,
// randomized frames against a list-based reference, and handshake corner cases.
module tb_ws2812_frame_ctrl;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] num_leds = '0;
  logic [7:0]        brightness = '0;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_rd_en;
  logic [23:0]       pix_data;
  logic [7:0]        r, g, b;
  logic              load, ws_reset, ready, busy, done;

  ws2812_frame_ctrl #(.ADDR_W(ADDR_W), .GUARD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .num_leds(num_leds),
    .brightness(brightness), .pix_addr(pix_addr), .pix_rd_en(pix_rd_en),
    .pix_data(pix_data), .r(r), .g(g), .b(b), .load(load),
    .ws_reset(ws_reset), .ready(ready), .busy(busy), .done(done)
  );

  always #10 clk = ~clk;

  logic [23:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (pix_rd_en) pix_data <= ram[pix_addr];

  // Driver: ready drops the cycle after a load/latch for a random time.
  int   drv_cnt;
  logic hold = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) drv_cnt <= 0;
    else if (load) drv_cnt <= int'($urandom_range(1, 6));
    else if (ws_reset) drv_cnt <= int'($urandom_range(1, 4));
    else if (drv_cnt != 0) drv_cnt <= drv_cnt - 1;
  end
  assign ready = (drv_cnt == 0) && !hold;

  int total = 0;
  int bad = 0;

  logic [23:0]       load_q [$];
  logic [ADDR_W-1:0] addr_q [$];
  int ws_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (pix_rd_en) addr_q.push_back(pix_addr);
      if (load) load_q.push_back({r, g, b});
      if (ws_reset) ws_cnt++;
      if (done) done_cnt++;
      if ((load && !ready) || (ws_reset && !ready) || (load && ws_reset)) begin
        bad++;
        $display("FAIL handshake: load=%0b ws_reset=%0b ready=%0b at %0t",
                 load, ws_reset, ready, $time);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    load_q.delete();
    addr_q.delete();
    ws_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic start_frame(input int n, input int br);
    num_leds = ADDR_W'(n);
    brightness = 8'(br);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int c = 0;
    while (done_cnt < target && c < budget) begin
      tick(1);
      c++;
    end
    if (done_cnt < target) begin
      bad++;
      $display("FAIL timeout: done count %0d expected %0d", done_cnt, target);
    end
  endtask

  function automatic logic [23:0] model(input logic [23:0] px, input int br);
    int rr, gg, bb;
    rr = (int'(px[23:16]) * (br + 1)) / 256;
    gg = (int'(px[15:8])  * (br + 1)) / 256;
    bb = (int'(px[7:0])   * (br + 1)) / 256;
    return {8'(rr), 8'(gg), 8'(bb)};
  endfunction

  task automatic check_frame(input int n, input int br);
    chk("load_count", load_q.size(), n);
    for (int i = 0; i < n && i < load_q.size(); i++)
      chk("load_rgb", load_q[i], model(ram[i], br));
    chk("rd_count", addr_q.size(), n);
    for (int i = 0; i < n && i < addr_q.size(); i++)
      chk("pix_addr", addr_q[i], i);
    chk("ws_reset_count", ws_cnt, 1);
    chk("done_count", done_cnt, 1);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic run_frame(input int n, input int br);
    clear_obs();
    start_frame(n, br);
    wait_done(1, 40 * n + 60);
    check_frame(n, br);
  endtask

  typedef struct {
    logic [23:0] pix;
    int          br;
    logic [23:0] exp;
  } vec_t;

  vec_t vt [6];

  initial begin
    vt[0] = '{24'hFF8040, 127, 24'h7F4020};
    vt[1] = '{24'hFF8040, 0,   24'h000000};
    vt[2] = '{24'h123456, 255, 24'h123456};
    vt[3] = '{24'hFFFFFF, 128, 24'h808080};
    vt[4] = '{24'h010203, 254, 24'h000102};
    vt[5] = '{24'h80C0FF, 63,  24'h20303F};

    #25;
    chk("reset_outputs", {pix_addr, r, g, b, pix_rd_en, load, ws_reset, busy, done}, '0);
    tick(1);
    rst = 1'b0;

    // Driver holds ready low for 100 cycles after reset.
    hold = 1'b1;
    clear_obs();
    ram[0] = 24'hA5A5A5;
    start_frame(1, 255);
    tick(100);
    chk("no_load_while_not_ready", load_q.size(), 0);
    chk("fetch_before_ready", addr_q.size(), 1);
    hold = 1'b0;
    wait_done(1, 100);
    check_frame(1, 255);

    ram[0] = 24'hFF0000; ram[1] = 24'h00FF00; ram[2] = 24'h0000FF;
    run_frame(3, 255);
    if (load_q.size() == 3) begin
      chk("rgb_red",   load_q[0], 24'hFF0000);
      chk("rgb_green", load_q[1], 24'h00FF00);
      chk("rgb_blue",  load_q[2], 24'h0000FF);
    end

    for (int i = 0; i < 6; i++) begin
      ram[0] = vt[i].pix;
      clear_obs();
      start_frame(1, vt[i].br);
      wait_done(1, 100);
      chk("vec_load_count", load_q.size(), 1);
      if (load_q.size() > 0) chk("vec_scaled_rgb", load_q[0], vt[i].exp);
    end

    // Empty frame still latches.
    clear_obs();
    start_frame(0, 200);
    wait_done(1, 100);
    chk("empty_rd", addr_q.size(), 0);
    chk("empty_load", load_q.size(), 0);
    chk("empty_ws_reset", ws_cnt, 1);
    chk("empty_done", done_cnt, 1);
    chk("rgb_retained", {r, g, b}, vt[5].exp);

    for (int f = 0; f < 10; f++) begin
      int n, br;
      n = int'($urandom_range(1, 8));
      br = int'($urandom_range(0, 255));
      for (int i = 0; i < n; i++) ram[i] = 24'($urandom);
      run_frame(n, br);
    end

    // start held high throughout a 2-LED frame, and in the cycle after done.
    ram[0] = 24'h102030; ram[1] = 24'h405060;
    clear_obs();
    num_leds = ADDR_W'(2);
    brightness = 8'd255;
    start = 1'b1;
    begin
      int c = 0;
      while (done_cnt == 0 && c < 200) begin tick(1); c++; end
    end
    chk("hold_start_loads", load_q.size(), 2);
    chk("hold_start_ws", ws_cnt, 1);
    chk("hold_start_done", done_cnt, 1);
    tick(1);
    start = 1'b0;
    wait_done(2, 200);
    chk("second_frame_loads", load_q.size(), 4);
    chk("second_frame_ws", ws_cnt, 2);
    chk("second_frame_addr", addr_q.size() == 4 ? addr_q[2] : 32'hFFFF, 0);

    // Async reset in the guard after LED 1 of a 4-LED frame.
    for (int i = 0; i < 4; i++) ram[i] = 24'($urandom);
    clear_obs();
    start_frame(4, 99);
    begin
      int c = 0;
      while (load_q.size() < 2 && c < 200) begin tick(1); c++; end
    end
    chk("reached_led1", load_q.size(), 2);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {pix_addr, r, g, b, pix_rd_en, load, ws_reset, busy, done}, '0);
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("no_done_after_reset", done_cnt, 0);
    run_frame(4, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
